// File: rtl/ray_column_sequencer.sv
// Frame sweep controller. For each screen column it launches the horizontal
// and vertical wall finders, waits for both to finish, picks the nearer hit
// and offers {column, distance, side} on a valid/ready handshake.
// Optional build macro: SQUARED_DIST_EN selects squared Euclidean distance
// and adds one register stage inside S_SELECT. When it is undefined,
// Manhattan distance is used and no multipliers are built.
module ray_column_sequencer #(
  parameter int NUM_COLS = 320,
  parameter int FOV      = 60,
  parameter int FRAC     = 8,
  parameter int COORD_W  = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start_frame,
  input  logic [COORD_W-1:0]   player_x,
  input  logic [COORD_W-1:0]   player_y,
  input  logic [11:0]          player_angle,
  output logic [11:0]          ray_alpha,
  output logic                 horiz_begin,
  output logic                 vert_begin,
  input  logic                 horiz_end,
  input  logic                 horiz_found,
  input  logic [COORD_W-1:0]   horiz_x,
  input  logic [COORD_W-1:0]   horiz_y,
  input  logic                 vert_end,
  input  logic                 vert_found,
  input  logic [COORD_W-1:0]   vert_x,
  input  logic [COORD_W-1:0]   vert_y,
  output logic                 col_valid,
  input  logic                 col_ready,
  output logic [8:0]           col_index,
  output logic [2*COORD_W:0]   col_dist,
  output logic                 col_side,
  output logic                 col_hit,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int DIST_W = 2*COORD_W + 1;
  localparam int ACC_W  = FRAC + 10;  // holds 360<<FRAC with headroom
  localparam logic [ACC_W-1:0] STEP = ACC_W'((FOV << FRAC) / NUM_COLS);
  localparam logic [ACC_W-1:0] FULL = ACC_W'(360 << FRAC);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_LAUNCH, S_WAIT, S_SELECT, S_EMIT, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [8:0]           col_index_q, col_index_d;
  logic [COORD_W-1:0]   px_q, px_d, py_q, py_d;
  logic                 h_done_q, h_done_d, v_done_q, v_done_d;
  logic                 hf_q, hf_d, vf_q, vf_d;
  logic [COORD_W-1:0]   hx_q, hx_d, hy_q, hy_d, vx_q, vx_d, vy_q, vy_d;
  logic [DIST_W-1:0]    dist_q, dist_d;
  logic                 side_q, side_d, hit_q, hit_d;
  logic [DIST_W-1:0]    hd_c, vd_c, hd_s, vd_s;
  logic [DIST_W-1:0]    sel_dist;
  logic                 sel_side, sel_hit;
  logic [11:0]          ang_m, ang_s, a0;
`ifdef SQUARED_DIST_EN
  localparam int SQ_W = 2*COORD_W;
  logic                 sel_ph_q, sel_ph_d;
  logic [DIST_W-1:0]    hd_q, hd_d, vd_q, vd_d;
`endif

  function automatic logic [COORD_W-1:0] absdiff(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  // Per-side distance from captured hit to the latched player position
  always_comb begin
    logic [COORD_W-1:0] hdx, hdy, vdx, vdy;
    hdx = absdiff(hx_q, px_q);
    hdy = absdiff(hy_q, py_q);
    vdx = absdiff(vx_q, px_q);
    vdy = absdiff(vy_q, py_q);
`ifdef SQUARED_DIST_EN
    hd_c = DIST_W'(SQ_W'(hdx) * SQ_W'(hdx)) + DIST_W'(SQ_W'(hdy) * SQ_W'(hdy));
    vd_c = DIST_W'(SQ_W'(vdx) * SQ_W'(vdx)) + DIST_W'(SQ_W'(vdy) * SQ_W'(vdy));
    hd_s = hd_q;
    vd_s = vd_q;
`else
    hd_c = DIST_W'({1'b0, hdx} + {1'b0, hdy});
    vd_c = DIST_W'({1'b0, vdx} + {1'b0, vdy});
    hd_s = hd_c;
    vd_s = vd_c;
`endif
  end

  // Nearer-hit choice; a tie goes to the horizontal side
  always_comb begin
    sel_dist = '1;
    sel_side = 1'b0;
    sel_hit  = hf_q | vf_q;
    if (hf_q && vf_q) begin
      sel_side = (vd_s < hd_s);
      sel_dist = (vd_s < hd_s) ? vd_s : hd_s;
    end else if (hf_q) begin
      sel_dist = hd_s;
    end else if (vf_q) begin
      sel_side = 1'b1;
      sel_dist = vd_s;
    end
  end

  // Starting ray angle: view angle folded into 0..359, plus half the FOV
  always_comb begin
    ang_m = (player_angle >= 12'd360) ? player_angle - 12'd360 : player_angle;
    ang_s = ang_m + 12'(FOV / 2);
    a0    = (ang_s >= 12'd360) ? ang_s - 12'd360 : ang_s;
  end

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    col_index_d = col_index_q;
    px_d = px_q;  py_d = py_q;
    h_done_d = h_done_q;  v_done_d = v_done_q;
    hf_d = hf_q;  hx_d = hx_q;  hy_d = hy_q;
    vf_d = vf_q;  vx_d = vx_q;  vy_d = vy_q;
    dist_d = dist_q;  side_d = side_q;  hit_d = hit_q;
`ifdef SQUARED_DIST_EN
    sel_ph_d = sel_ph_q;  hd_d = hd_q;  vd_d = vd_q;
`endif
    case (state_q)
      S_IDLE: if (start_frame) state_d = S_LATCH;
      S_LATCH: begin
        px_d        = player_x;
        py_d        = player_y;
        acc_d       = ACC_W'(a0) << FRAC;
        col_index_d = '0;
        state_d     = S_LAUNCH;
      end
      S_LAUNCH: begin
        h_done_d = 1'b0;
        v_done_d = 1'b0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (horiz_end && !h_done_q) begin
          h_done_d = 1'b1;  hf_d = horiz_found;  hx_d = horiz_x;  hy_d = horiz_y;
        end
        if (vert_end && !v_done_q) begin
          v_done_d = 1'b1;  vf_d = vert_found;  vx_d = vert_x;  vy_d = vert_y;
        end
        if ((h_done_q || horiz_end) && (v_done_q || vert_end)) state_d = S_SELECT;
      end
      S_SELECT: begin
`ifdef SQUARED_DIST_EN
        if (!sel_ph_q) begin
          sel_ph_d = 1'b1;
          hd_d     = hd_c;
          vd_d     = vd_c;
        end else begin
          sel_ph_d = 1'b0;
          dist_d = sel_dist;  side_d = sel_side;  hit_d = sel_hit;
          state_d = S_EMIT;
        end
`else
        dist_d = sel_dist;  side_d = sel_side;  hit_d = sel_hit;
        state_d = S_EMIT;
`endif
      end
      S_EMIT: if (col_ready) begin
        if (col_index_q == 9'(NUM_COLS - 1)) begin
          state_d = S_DONE;
        end else begin
          col_index_d = col_index_q + 9'd1;
          acc_d   = (acc_q < STEP) ? acc_q + FULL - STEP : acc_q - STEP;
          state_d = S_LAUNCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;  acc_q <= '0;  col_index_q <= '0;
      px_q <= '0;  py_q <= '0;  h_done_q <= 1'b0;  v_done_q <= 1'b0;
      hf_q <= 1'b0;  hx_q <= '0;  hy_q <= '0;
      vf_q <= 1'b0;  vx_q <= '0;  vy_q <= '0;
      dist_q <= '0;  side_q <= 1'b0;  hit_q <= 1'b0;
`ifdef SQUARED_DIST_EN
      sel_ph_q <= 1'b0;  hd_q <= '0;  vd_q <= '0;
`endif
    end else begin
      state_q <= state_d;  acc_q <= acc_d;  col_index_q <= col_index_d;
      px_q <= px_d;  py_q <= py_d;  h_done_q <= h_done_d;  v_done_q <= v_done_d;
      hf_q <= hf_d;  hx_q <= hx_d;  hy_q <= hy_d;
      vf_q <= vf_d;  vx_q <= vx_d;  vy_q <= vy_d;
      dist_q <= dist_d;  side_q <= side_d;  hit_q <= hit_d;
`ifdef SQUARED_DIST_EN
      sel_ph_q <= sel_ph_d;  hd_q <= hd_d;  vd_q <= vd_d;
`endif
    end
  end

  assign ray_alpha   = 12'(acc_q >> FRAC);
  assign horiz_begin = (state_q == S_LAUNCH);
  assign vert_begin  = (state_q == S_LAUNCH);
  assign col_valid   = (state_q == S_EMIT);
  assign col_index   = col_index_q;
  assign col_dist    = dist_q;
  assign col_side    = side_q;
  assign col_hit     = hit_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = (state_q == S_DONE);
endmodule

// File: tb/tb_ray_column_sequencer.sv
// Randomized self-checking bench for ray_column_sequencer (NUM_COLS=4).
// Expected angles come from modular arithmetic on the sweep, expected results
// from the nearest-hit rules; define SQUARED_DIST_EN to match that build.
module tb_ray_column_sequencer;
  localparam int NC = 4, FOV = 60, FRAC = 8, CW = 12, DW = 2*CW + 1;
  localparam longint ALL1 = (64'd1 << DW) - 1;

  logic clock = 1'b0, reset = 1'b1;
  logic start_frame = 0, horiz_end = 0, horiz_found = 0, vert_end = 0, vert_found = 0;
  logic col_ready = 0;
  logic [CW-1:0] player_x = 0, player_y = 0, horiz_x = 0, horiz_y = 0, vert_x = 0, vert_y = 0;
  logic [11:0] player_angle = 0, ray_alpha;
  logic horiz_begin, vert_begin, col_valid, col_side, col_hit, busy, frame_done;
  logic [8:0] col_index;
  logic [DW-1:0] col_dist;

  ray_column_sequencer #(.NUM_COLS(NC), .FOV(FOV), .FRAC(FRAC), .COORD_W(CW)) dut (
    .clock(clock), .reset(reset), .start_frame(start_frame),
    .player_x(player_x), .player_y(player_y), .player_angle(player_angle),
    .ray_alpha(ray_alpha), .horiz_begin(horiz_begin), .vert_begin(vert_begin),
    .horiz_end(horiz_end), .horiz_found(horiz_found), .horiz_x(horiz_x), .horiz_y(horiz_y),
    .vert_end(vert_end), .vert_found(vert_found), .vert_x(vert_x), .vert_y(vert_y),
    .col_valid(col_valid), .col_ready(col_ready), .col_index(col_index),
    .col_dist(col_dist), .col_side(col_side), .col_hit(col_hit),
    .busy(busy), .frame_done(frame_done));

  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0;
  int hf[NC], hx[NC], hy[NC], vf[NC], vx[NC], vy[NC], dh[NC], dv[NC], bp[NC];
  int px, py, pang;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Ray k sits k*STEP below the start angle, modulo a full turn
  function automatic int exp_alpha(int ang, int k);
    longint step = (FOV * 256) / NC, full = 360 * 256;
    longint a0 = ((ang % 360) + FOV / 2) % 360;
    longint a  = ((a0 * 256 - k * step) % full + full) % full;
    return int'(a / 256);
  endfunction

  function automatic longint exp_d(int x, int y);
    longint dx = (x > px) ? x - px : px - x;
    longint dy = (y > py) ? y - py : py - y;
`ifdef SQUARED_DIST_EN
    return dx * dx + dy * dy;
`else
    return dx + dy;
`endif
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_alpha"}, ray_alpha, 0);   chk({tag, "_hbeg"}, horiz_begin, 0);
    chk({tag, "_vbeg"}, vert_begin, 0);   chk({tag, "_valid"}, col_valid, 0);
    chk({tag, "_idx"}, col_index, 0);     chk({tag, "_dist"}, col_dist, 0);
    chk({tag, "_side"}, col_side, 0);     chk({tag, "_hit"}, col_hit, 0);
    chk({tag, "_busy"}, busy, 0);         chk({tag, "_done"}, frame_done, 0);
  endtask

  task automatic rand_col(input int k);
    hf[k] = $urandom_range(0, 3) != 0;  vf[k] = $urandom_range(0, 3) != 0;
    hx[k] = $urandom_range(0, 4095);    hy[k] = $urandom_range(0, 4095);
    vx[k] = $urandom_range(0, 4095);    vy[k] = $urandom_range(0, 4095);
    dh[k] = $urandom_range(1, 6);       dv[k] = $urandom_range(1, 6);
    bp[k] = $urandom_range(0, 7);
  endtask

  // One frame; abort_col >= 0 asserts reset inside S_WAIT of that column
  task automatic run_frame(input int abort_col);
    int t, m, rep, lat, es, eh;
    longint ed, dH, dV;
    @(posedge clock); #1;
    player_x = CW'(px); player_y = CW'(py); player_angle = 12'(pang); start_frame = 1;
    @(posedge clock); #1;
    start_frame = 0;
    chk("busy_start", busy, 1);
    for (int k = 0; k < NC; k++) begin
      t = 0;
      while (!horiz_begin && t < 20) begin @(posedge clock); #1; t++; end
      chk("launch_seen", horiz_begin, 1);
      if (!horiz_begin) return;
      chk("vbegin", vert_begin, 1);
      chk("alpha", ray_alpha, exp_alpha(pang, k));
      chk("index", col_index, k);
      m = (dh[k] > dv[k]) ? dh[k] : dv[k];
      rep = $urandom_range(0, 1);
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
        @(posedge clock); #1;
        if (c == 1) begin chk("hbeg_pulse", horiz_begin, 0); chk("vbeg_pulse", vert_begin, 0); end
        if (k == abort_col && c == 2) begin
          reset = 1; #1;
          chk_idle("abort");
          horiz_end = 0; vert_end = 0;
          return;
        end
        if (col_valid) begin lat = c; break; end
        chk("alpha_hold", ray_alpha, exp_alpha(pang, k));
        horiz_end   = (c == dh[k]) || (rep != 0 && c == dh[k] + 1);
        horiz_found = (c == dh[k]) ? 1'(hf[k]) : 1'($urandom_range(0, 1));
        horiz_x     = (c == dh[k]) ? CW'(hx[k]) : CW'($urandom);
        horiz_y     = (c == dh[k]) ? CW'(hy[k]) : CW'($urandom);
        vert_end    = (c == dv[k]) || (rep != 0 && c == dv[k] + 1);
        vert_found  = (c == dv[k]) ? 1'(vf[k]) : 1'($urandom_range(0, 1));
        vert_x      = (c == dv[k]) ? CW'(vx[k]) : CW'($urandom);
        vert_y      = (c == dv[k]) ? CW'(vy[k]) : CW'($urandom);
        col_ready   = 1'($urandom_range(0, 1));
      end
      horiz_end = 0; vert_end = 0; col_ready = 0;
`ifdef SQUARED_DIST_EN
      chk("latency", lat, m + 3);
`else
      chk("latency", lat, m + 2);
`endif
      if (lat < 0) return;
      dH = exp_d(hx[k], hy[k]);  dV = exp_d(vx[k], vy[k]);
      eh = (hf[k] != 0 || vf[k] != 0);
      if (hf[k] != 0 && vf[k] != 0) begin es = (dV < dH); ed = (dV < dH) ? dV : dH; end
      else if (hf[k] != 0)          begin es = 0; ed = dH; end
      else if (vf[k] != 0)          begin es = 1; ed = dV; end
      else                          begin es = 0; ed = ALL1; end
      for (int b = 0; b <= bp[k]; b++) begin
        chk("valid", col_valid, 1);  chk("dist", col_dist, ed);
        chk("side", col_side, es);   chk("hit", col_hit, eh);
        chk("idx_hold", col_index, k);  chk("no_launch", horiz_begin, 0);
        chk("busy", busy, 1);
        col_ready = (b == bp[k]);
        start_frame = 1'($urandom_range(0, 1));
        @(posedge clock); #1;
      end
      col_ready = 0; start_frame = 0;
    end
    chk("frame_done", frame_done, 1);
    chk("no_valid_done", col_valid, 0);
    @(posedge clock); #1;
    chk("done_pulse", frame_done, 0);
    chk("busy_end", busy, 0);
    repeat (3) begin
      @(posedge clock); #1;
      chk("idle_stays", busy, 0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk_idle("reset");
    reset = 0;
    // Angle sweep, finders done on the first cycle
    px = 100; py = 100; pang = 10;
    for (int k = 0; k < NC; k++) begin
      hf[k] = 1; hx[k] = 100; hy[k] = 63; vf[k] = 1; vx[k] = 128; vy[k] = 80;
      dh[k] = 1; dv[k] = 1; bp[k] = 0;
    end
    run_frame(-1);
    chk("sweep_c3", exp_alpha(10, 3), 355);
    // Select, one-sided, miss and tie cases with backpressure
    pang = 700;
    for (int k = 0; k < NC; k++) begin rand_col(k); end
    hf[0] = 1; hx[0] = 100; hy[0] = 63;  vf[0] = 1; vx[0] = 128; vy[0] = 80;
    hf[1] = 0; vf[1] = 1; vx[1] = 90; vy[1] = 100;
    hf[2] = 0; vf[2] = 0;
    hf[3] = 1; hx[3] = 110; hy[3] = 100; vf[3] = 1; vx[3] = 100; vy[3] = 110; bp[3] = 7;
    run_frame(-1);
    // End ordering: vertical far ahead, then both together
    pang = 359;
    for (int k = 0; k < NC; k++) begin rand_col(k); end
    dv[0] = 1; dh[0] = 6;  dh[1] = 3; dv[1] = 3;
    run_frame(-1);
    // Random frames
    for (int f = 0; f < 6; f++) begin
      px = $urandom_range(0, 4095); py = $urandom_range(0, 4095);
      pang = $urandom_range(0, 719);
      for (int k = 0; k < NC; k++) begin rand_col(k); end
      run_frame(-1);
    end
    // Reset during S_WAIT of column 2, then a clean restart
    for (int k = 0; k < NC; k++) begin rand_col(k); dh[k] = 6; dv[k] = 6; end
    pang = 123;
    run_frame(2);
    repeat (3) begin
      @(posedge clock); #1;
      chk("held_done", frame_done, 0);
      chk("held_busy", busy, 0);
    end
    reset = 0;
    for (int k = 0; k < NC; k++) begin rand_col(k); end
    run_frame(-1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
